// File: rtl/dpll_pkg.sv
// rtl/dpll_pkg.sv - shared types and helpers for the DPLL loop controller
package dpll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RETARD  = 2'd1,
        ADVANCE = 2'd2,
        HOLDOFF = 2'd3
    } dpll_state_e;

    localparam logic DIR_ADV = 1'b0;
    localparam logic DIR_RET = 1'b1;

    // One extra bit over log2 so the walk can be held as a signed value.
    function automatic int walk_width(input int k_mod);
        return $clog2(k_mod) + 1;
    endfunction

endpackage

// File: rtl/dpll_lock_det.sv
// rtl/dpll_lock_det.sv - quiet-time and same-direction-run lock detector
//
// Ports:
//   clk        loop clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of all lock state (loop disabled)
//   corr_start one-cycle strobe: a correction is starting this cycle
//   corr_dir   direction of that correction (DIR_ADV / DIR_RET)
//   lock       registered lock indication
module dpll_lock_det
    import dpll_pkg::*;
#(
    parameter int LOCK_QUIET = 256,
    parameter int LOCK_LOSS  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic corr_start,
    input  logic corr_dir,
    output logic lock
);

    localparam int QW = $clog2(LOCK_QUIET + 1);
    localparam int RW = $clog2(LOCK_LOSS + 1);

    logic [QW-1:0] quiet_q, quiet_d;
    logic [RW-1:0] run_q, run_d;
    logic          last_dir_q, last_dir_d;
    logic          lock_q, lock_d;

    always_comb begin
        quiet_d    = quiet_q;
        run_d      = run_q;
        last_dir_d = last_dir_q;
        lock_d     = lock_q;

        if (corr_start) begin
            quiet_d    = '0;
            last_dir_d = corr_dir;
            // run_q == 0 means no earlier correction to compare against
            if (run_q != '0 && corr_dir == last_dir_q) begin
                run_d = (run_q == RW'(LOCK_LOSS)) ? run_q : run_q + RW'(1);
            end else begin
                run_d = RW'(1);
            end
        end else if (quiet_q != QW'(LOCK_QUIET)) begin
            quiet_d = quiet_q + QW'(1);
        end

        if (quiet_d == QW'(LOCK_QUIET)) begin
            lock_d = 1'b1;
        end
        // Clear is evaluated last so it wins over a same-cycle set.
        if (corr_start && run_d >= RW'(LOCK_LOSS)) begin
            lock_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quiet_q    <= '0;
            run_q      <= '0;
            last_dir_q <= DIR_ADV;
            lock_q     <= 1'b0;
        end else if (clr) begin
            quiet_q    <= '0;
            run_q      <= '0;
            last_dir_q <= DIR_ADV;
            lock_q     <= 1'b0;
        end else begin
            quiet_q    <= quiet_d;
            run_q      <= run_d;
            last_dir_q <= last_dir_d;
            lock_q     <= lock_d;
        end
    end

    assign lock = lock_q;

endmodule

// File: rtl/dpll_loop_ctrl.sv
// rtl/dpll_loop_ctrl.sv - DPLL random-walk loop filter and pulse delete/insert sequencer
//
// Ports:
//   clk32_i     loop clock (32x reference)
//   rst_n_i     asynchronous active-low reset
//   en_i        loop enable; low returns to a clean IDLE on the next edge
//   lead_i      strobe: local clock leads the input
//   lag_i       strobe: local clock lags the input
//   pd_before_o delete-pulse gate to the divider (retard)
//   pd_after_o  insert-pulse gate to the divider (advance)
//   busy_o      correction or hold-off in progress
//   walk_o      signed random-walk counter
//   lock_o      loop locked
//   adv_cnt_o / ret_cnt_o  saturating correction counters, present only
//                          when DPLL_CORR_STATS_EN is defined
module dpll_loop_ctrl
    import dpll_pkg::*;
#(
    parameter int K_MOD       = 8,
    parameter int CORR_LEN    = 4,
    parameter int HOLDOFF_LEN = 16,
    parameter int LOCK_QUIET  = 256,
    parameter int LOCK_LOSS   = 3
) (
    input  logic                          clk32_i,
    input  logic                          rst_n_i,
    input  logic                          en_i,
    input  logic                          lead_i,
    input  logic                          lag_i,
    output logic                          pd_before_o,
    output logic                          pd_after_o,
    output logic                          busy_o,
    output logic [walk_width(K_MOD)-1:0]  walk_o,
    output logic                          lock_o
`ifdef DPLL_CORR_STATS_EN
    ,
    output logic [15:0]                   adv_cnt_o,
    output logic [15:0]                   ret_cnt_o
`endif
);

    localparam int WW   = walk_width(K_MOD);
    localparam int PMAX = (CORR_LEN > HOLDOFF_LEN) ? CORR_LEN : HOLDOFF_LEN;
    localparam int PW   = $clog2(PMAX + 1);

    // One bit wider than the walk so +K_MOD is representable for the compare.
    localparam logic signed [WW:0] K_POS = (WW+1)'(K_MOD);
    localparam logic signed [WW:0] K_NEG = -K_POS;

    dpll_state_e              state_q, state_d;
    logic [PW-1:0]            cnt_q, cnt_d;
    logic signed [WW-1:0]     walk_q, walk_d;
    logic signed [WW:0]       step;
    logic signed [WW:0]       walk_ext;
    logic                     corr_start;
    logic                     corr_dir;
    logic                     pd_before_q, pd_after_q, busy_q;

    always_comb begin
        step = '0;
        if (lead_i && !lag_i) begin
            step = {{WW{1'b0}}, 1'b1};
        end else if (lag_i && !lead_i) begin
            step = '1;
        end
        walk_ext = $signed({walk_q[WW-1], walk_q}) + step;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        walk_d     = walk_q;
        corr_start = 1'b0;
        corr_dir   = DIR_ADV;

        case (state_q)
            IDLE: begin
                if (walk_ext == K_POS) begin
                    state_d    = RETARD;
                    cnt_d      = '0;
                    walk_d     = '0;
                    corr_start = 1'b1;
                    corr_dir   = DIR_RET;
                end else if (walk_ext == K_NEG) begin
                    state_d    = ADVANCE;
                    cnt_d      = '0;
                    walk_d     = '0;
                    corr_start = 1'b1;
                    corr_dir   = DIR_ADV;
                end else begin
                    walk_d = walk_ext[WW-1:0];
                end
            end
            RETARD, ADVANCE: begin
                walk_d = '0;
                if (cnt_q == PW'(CORR_LEN - 1)) begin
                    state_d = HOLDOFF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            HOLDOFF: begin
                walk_d = '0;
                if (cnt_q == PW'(HOLDOFF_LEN - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                walk_d  = '0;
            end
        endcase

        if (!en_i) begin
            state_d    = IDLE;
            cnt_d      = '0;
            walk_d     = '0;
            corr_start = 1'b0;
        end
    end

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            walk_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            walk_q  <= walk_d;
        end
    end

    // Gates follow the state one edge later so the divider sees the window
    // starting the edge after the threshold strobe; en_i low kills them at once.
    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pd_before_q <= 1'b0;
            pd_after_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            pd_before_q <= en_i && (state_q == RETARD);
            pd_after_q  <= en_i && (state_q == ADVANCE);
            busy_q      <= en_i && (state_q != IDLE);
        end
    end

    dpll_lock_det #(
        .LOCK_QUIET (LOCK_QUIET),
        .LOCK_LOSS  (LOCK_LOSS)
    ) u_lock_det (
        .clk        (clk32_i),
        .rst_n      (rst_n_i),
        .clr        (!en_i),
        .corr_start (corr_start),
        .corr_dir   (corr_dir),
        .lock       (lock_o)
    );

`ifdef DPLL_CORR_STATS_EN
    logic [15:0] adv_cnt_q, ret_cnt_q;

    always_ff @(posedge clk32_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            adv_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (!en_i) begin
            adv_cnt_q <= '0;
            ret_cnt_q <= '0;
        end else if (corr_start) begin
            if (corr_dir == DIR_ADV && adv_cnt_q != 16'hFFFF) begin
                adv_cnt_q <= adv_cnt_q + 16'd1;
            end
            if (corr_dir == DIR_RET && ret_cnt_q != 16'hFFFF) begin
                ret_cnt_q <= ret_cnt_q + 16'd1;
            end
        end
    end

    assign adv_cnt_o = adv_cnt_q;
    assign ret_cnt_o = ret_cnt_q;
`endif

    assign pd_before_o = pd_before_q;
    assign pd_after_o  = pd_after_q;
    assign busy_o      = busy_q;
    assign walk_o      = walk_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
// tb/tb_dpll_loop_ctrl.sv - scoreboard bench for dpll_loop_ctrl against a time-based loop model
module tb_dpll_loop_ctrl;

    localparam int K  = 8;
    localparam int CL = 4;
    localparam int HL = 16;
    localparam int LQ = 256;
    localparam int LL = 3;
    localparam int WW = $clog2(K) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          lead;
    logic          lag;
    logic          pd_before;
    logic          pd_after;
    logic          busy;
    logic [WW-1:0] walk;
    logic          lock;
`ifdef DPLL_CORR_STATS_EN
    logic [15:0]   adv_cnt;
    logic [15:0]   ret_cnt;
`endif

    dpll_loop_ctrl #(
        .K_MOD       (K),
        .CORR_LEN    (CL),
        .HOLDOFF_LEN (HL),
        .LOCK_QUIET  (LQ),
        .LOCK_LOSS   (LL)
    ) dut (
        .clk32_i     (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .lead_i      (lead),
        .lag_i       (lag),
        .pd_before_o (pd_before),
        .pd_after_o  (pd_after),
        .busy_o      (busy),
        .walk_o      (walk),
        .lock_o      (lock)
`ifdef DPLL_CORR_STATS_EN
        ,
        .adv_cnt_o   (adv_cnt),
        .ret_cnt_o   (ret_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pdb;
        bit pda;
        bit busy;
        int walk;
        bit lock;
        int adv;
        int ret;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_x;

    int checks = 0;
    int errors = 0;

    // Model: m_t is cycles elapsed since the current correction started,
    // -1 when the loop is idle; m_dir is 1 for retard, 0 for advance.
    int m_walk, m_t, m_dir, m_quiet, m_run, m_last, m_adv, m_ret;
    bit m_lock;
    int n_corr;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_walk  = 0;
        m_t     = -1;
        m_dir   = 0;
        m_quiet = 0;
        m_run   = 0;
        m_last  = 0;
        m_adv   = 0;
        m_ret   = 0;
        m_lock  = 0;
    endfunction

    function automatic void model_step(input bit e, input bit l, input bit g);
        exp_t x;
        bit   active;
        bit   start;
        int   w;
        active = (m_t >= 0);
        x.pdb  = e && active && m_t < CL && m_dir == 1;
        x.pda  = e && active && m_t < CL && m_dir == 0;
        x.busy = e && active;
        if (!e) begin
            model_reset();
        end else begin
            start = 0;
            if (active) begin
                m_t = m_t + 1;
                if (m_t == CL + HL) m_t = -1;
            end else begin
                w = m_walk;
                if (l && !g) w = w + 1;
                if (g && !l) w = w - 1;
                if (w == K || w == -K) begin
                    start  = 1;
                    m_dir  = (w == K) ? 1 : 0;
                    m_t    = 0;
                    m_walk = 0;
                end else begin
                    m_walk = w;
                end
            end
            if (start) begin
                n_corr++;
                m_quiet = 0;
                m_run   = (m_run > 0 && m_dir == m_last) ? m_run + 1 : 1;
                m_last  = m_dir;
                if (m_dir == 1) m_ret = (m_ret < 65535) ? m_ret + 1 : m_ret;
                else            m_adv = (m_adv < 65535) ? m_adv + 1 : m_adv;
            end else if (m_quiet < LQ) begin
                m_quiet = m_quiet + 1;
            end
            if (m_quiet == LQ) m_lock = 1;
            if (start && m_run >= LL) m_lock = 0;
        end
        x.walk = m_walk;
        x.lock = m_lock;
        x.adv  = m_adv;
        x.ret  = m_ret;
        sb_q.push_back(x);
    endfunction

    // Drive one cycle of stimulus and post the expected post-edge outputs.
    task automatic cyc(input bit e, input bit l, input bit g);
        en   = e;
        lead = l;
        lag  = g;
        @(posedge clk);
        model_step(e, l, g);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0);
    endtask

    task automatic strobes(input int n, input bit l, input bit g);
        for (int i = 0; i < n; i++) cyc(1'b1, l, g);
    endtask

    always @(negedge clk) begin
        if (rst_n && sb_q.size() > 0) begin
            mon_x = sb_q.pop_front();
            check("pd_before", int'(pd_before), int'(mon_x.pdb));
            check("pd_after",  int'(pd_after),  int'(mon_x.pda));
            check("busy",      int'(busy),      int'(mon_x.busy));
            check("walk",      int'($signed(walk)), mon_x.walk);
            check("lock",      int'(lock),      int'(mon_x.lock));
            if (pd_before && pd_after) check("pd_exclusive", 1, 0);
`ifdef DPLL_CORR_STATS_EN
            check("adv_cnt", int'(adv_cnt), mon_x.adv);
            check("ret_cnt", int'(ret_cnt), mon_x.ret);
`endif
        end
    end

    int pl, pg;

    initial begin
        n_corr = 0;
        model_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        lead  = 1'b0;
        lag   = 1'b0;

        // Reset holds every output low despite strobes.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1 lead = ~lead;
            @(negedge clk);
            check("rst_pd_before", int'(pd_before), 0);
            check("rst_pd_after",  int'(pd_after),  0);
            check("rst_busy",      int'(busy),      0);
            check("rst_walk",      int'(walk),      0);
            check("rst_lock",      int'(lock),      0);
        end
        lead  = 1'b0;
        rst_n = 1'b1;

        // Retard: 8 leads, then the full correction + hold-off.
        strobes(K, 1'b1, 1'b0);
        idle(CL + HL + 4);

        // Advance with lag strobes arriving during hold-off.
        strobes(K, 1'b0, 1'b1);
        idle(CL + 3);
        strobes(5, 1'b0, 1'b1);
        idle(HL);

        // Cancel: both strobes together never move the walk.
        strobes(20, 1'b1, 1'b1);

        // Lock acquisition, then three retard corrections drop it.
        idle(LQ + 4);
        for (int c = 0; c < LL; c++) begin
            strobes(K, 1'b1, 1'b0);
            idle(CL + HL + 2);
        end
        // Relock, then ADV followed by RET keeps lock.
        idle(LQ + 4);
        strobes(K, 1'b0, 1'b1);
        idle(CL + HL + 2);
        strobes(K, 1'b1, 1'b0);
        idle(CL + HL + 2);

        // Enable abort during retard cycle 2.
        strobes(K, 1'b1, 1'b0);
        idle(1);
        cyc(1'b0, 1'b1, 1'b0);
        idle(6);

        // Randomised segments with biased drift and occasional disable.
        for (int s = 0; s < 20; s++) begin
            pl = $urandom_range(0, 90);
            pg = $urandom_range(0, 90);
            for (int i = 0; i < 150; i++) begin
                cyc(($urandom_range(0, 199) != 0),
                    ($urandom_range(0, 99) < pl),
                    ($urandom_range(0, 99) < pg));
            end
        end

        // Asynchronous reset in the middle of a retard window.
        idle(CL + HL + 2);
        strobes(K, 1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        #2;
        check("pre_rst_pd_before", int'(pd_before), 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_pd_before", int'(pd_before), 0);
        check("async_rst_busy",      int'(busy),      0);
        check("async_rst_lock",      int'(lock),      0);
        sb_q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobes(K, 1'b0, 1'b1);
        idle(CL + HL + 4);

        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        check("corrections_seen", int'(n_corr >= 10), 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dpll_loop_ctrl.md
Name: dpll_loop_ctrl

Overview:
- Digital loop controller for the 50 kHz DPSK DPLL; sits between the phase detector and the gated divide-by-5 clock generator.
- Filters raw lead/lag strobes with a sequential random-walk (K-counter) filter.
- Sequences pulse-delete (pd_before_o) and pulse-insert (pd_after_o) windows for the divider, enforces a hold-off between corrections, and reports lock.

Parameters:
- K_MOD, 8: random-walk modulus; a correction fires when the walk counter reaches +K_MOD or -K_MOD.
- CORR_LEN, 4: clk32_i cycles that a pd_* output stays asserted per correction.
- HOLDOFF_LEN, 16: clk32_i cycles after a correction during which PD strobes are ignored.
- LOCK_QUIET, 256: consecutive correction-free clk32_i cycles required to assert lock.
- LOCK_LOSS, 3: consecutive same-direction corrections that drop lock.

Ports:
- clk32_i  input  1  loop clock (32x reference).
- rst_n_i  input  1  asynchronous active-low reset.
- en_i  input  1  loop enable.
- lead_i  input  1  single-cycle strobe: local clock leads the input.
- lag_i  input  1  single-cycle strobe: local clock lags the input.
- pd_before_o  output  1  delete-pulse gate to the divider.
- pd_after_o  output  1  insert-pulse gate to the divider.
- busy_o  output  1  correction or hold-off in progress.
- walk_o  output  $clog2(K_MOD)+1  signed walk counter value.
- lock_o  output  1  loop locked.

Behaviour:
- Reset is asynchronous and active-low on rst_n_i; the design has one clock, clk32_i.
- Reset values: all outputs 0, walk counter 0, FSM in IDLE, lock counters 0. Reset mid-correction drops the pd_* output immediately.
- All outputs are registered.
- FSM states: IDLE, RETARD, ADVANCE, HOLDOFF.
- IDLE:
  - lead_i alone: walk +1.
  - lag_i alone: walk -1.
  - Both asserted, or neither: walk holds.
- Threshold crossing:
  - Walk reaching +K_MOD goes to RETARD.
  - Walk reaching -K_MOD goes to ADVANCE.
  - In both cases the walk clears to 0 in the same cycle.
  - The walk never holds ±K_MOD for more than one cycle.
- Latency: if the strobe that hits the threshold is sampled at edge n, pd_before_o (RETARD) or pd_after_o (ADVANCE) is high from edge n+1 for exactly CORR_LEN cycles.
- After the correction window, the FSM enters HOLDOFF for HOLDOFF_LEN cycles and then returns to IDLE.
- In RETARD, ADVANCE and HOLDOFF, lead_i and lag_i are ignored and the walk stays at 0.
- pd_before_o and pd_after_o are never high together.
- busy_o = (state != IDLE).
- en_i low: synchronous return to IDLE next edge. Walk, pd_* outputs and lock are cleared, and strobes are ignored. Re-enabling starts from a clean IDLE.
- Lock detection:
  - A quiet counter increments each cycle with no correction start and saturates at LOCK_QUIET.
  - A correction start clears the quiet counter. lock_o sets when the count reaches LOCK_QUIET.
  - A direction run counter tracks consecutive corrections in the same direction and resets on a direction change.
  - lock_o clears on the LOCK_LOSS-th same-direction correction.
  - Set and clear in the same cycle: clear wins.
- Width: the walk is a signed two's-complement value of $clog2(K_MOD)+1 bits. The ±K_MOD compare is done before the update is committed, so there is no wrap.

Optional Feature:
- Macro: DPLL_CORR_STATS_EN.
- When defined:
  - Adds outputs adv_cnt_o[15:0] and ret_cnt_o[15:0], counting ADVANCE and RETARD entries.
  - Both counters saturate at 16'hFFFF and are cleared by reset or en_i low.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package dpll_pkg:
  - FSM state enum (IDLE, RETARD, ADVANCE, HOLDOFF).
  - Direction constants DIR_ADV and DIR_RET.
  - Function for the walk-counter width.
- Sub-module dpll_lock_det: quiet counter, direction run counter and lock_o. Driven by a correction-start strobe plus its direction.

Test Plan:
- Reset/idle: hold rst_n_i low, en_i=1, toggle lead_i -> all outputs 0. Release -> walk_o=0, FSM in IDLE.
- Retard: 8 lead_i strobes (K_MOD=8) -> walk_o ramps 1..7. pd_before_o is high for 4 cycles starting one edge after the 8th strobe, then busy_o stays high 16 more cycles, then goes low.
- Advance and hold-off: 8 lag_i strobes, then 5 lag_i strobes during HOLDOFF -> one pd_after_o pulse of 4 cycles only, and walk_o=0 on return to IDLE.
- Cancel: lead_i=lag_i=1 for 20 cycles -> walk_o stays 0, no pd_* activity.
- Lock: no strobes for 256 cycles -> lock_o=1. Then 3 RETARD corrections -> lock_o=0 on the 3rd start. An ADV then RET sequence does not clear lock_o.
- Enable abort: drop en_i during RETARD cycle 2 -> pd_before_o=0 next edge, walk_o=0, lock_o=0.
